// File: rtl/sp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_pkg
// Description : Shared types and geometry helpers for the banked SP RAM
//               wrapper (state encoding, bank/row address split).
// Revision    : 1.0 - initial banked release
// ============================================================================
package sp_ram_pkg;

    // Wrapper sequencer states: zero-fill sweep, then normal service
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int c_word_bytes = 4;

    // Bank index is at most 4 bits (16 banks); row is the rest of the word address
    typedef struct packed {
        logic [3:0]  bank;
        logic [29:0] row;
    } bank_row_t;

    // BANK_BITS helper
    function automatic int calc_bank_bits(input int num_banks);
        return $clog2(num_banks);
    endfunction

    // ROWS helper: words held by one bank
    function automatic int calc_rows(input int ram_size, input int num_banks);
        return ram_size / c_word_bytes / num_banks;
    endfunction

    // ROW_BITS helper, kept at least 1 bit wide so the row port always exists
    function automatic int calc_row_bits(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Word-interleaved split: low word-address bits pick the bank
    function automatic bank_row_t addr_to_bank_row(input logic [31:0] addr,
                                                   input int          bank_bits);
        logic [29:0] word;
        bank_row_t   res;
        word     = addr[31:2];
        res.bank = 4'(word & ((30'd1 << bank_bits) - 30'd1));
        res.row  = word >> bank_bits;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram_banked_wrap_bank.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_bank
// Description : One ROWS x 32 single-port bank with byte enables. Selects the
//               FPGA or ASIC macro under the usual defines, otherwise a
//               behavioural sp_ram-equivalent array.
// Revision    : 1.0 - initial banked release
// ============================================================================
module sp_ram_bank #(
    parameter int ROWS     = 2048,
    parameter int ROW_BITS = 11
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [3:0]          be,
    input  logic [ROW_BITS-1:0] addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata
);

`ifdef PULP_FPGA_EMUL
    fpga_sp_ram #(
        .ROWS     (ROWS),
        .ROW_BITS (ROW_BITS)
    ) u_macro (
        .clk   (clk),
        .en    (en),
        .we    (we),
        .be    (be),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );
`elsif PULP_ASIC
    asic_sp_ram #(
        .ROWS     (ROWS),
        .ROW_BITS (ROW_BITS)
    ) u_macro (
        .clk   (clk),
        .en    (en),
        .we    (we),
        .be    (be),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );
`else
    logic [31:0] r_mem [ROWS];
    logic [31:0] r_rdata;

    // Synchronous single-port access; the read register holds between reads
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;
`endif

endmodule
`default_nettype wire

// File: rtl/sp_ram_banked_wrap.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_banked_wrap
// Description : Word-interleaved multi-bank single-port RAM wrapper with
//               req/gnt/rvalid handshake, range error, optional output
//               register and optional post-reset zero-fill.
// Revision    : 1.0 - initial banked release
// ============================================================================
module sp_ram_banked_wrap
    import sp_ram_pkg::*;
#(
    parameter int RAM_SIZE   = 32768,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4,
    parameter int OUT_REG    = 0,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  init_done_o
);

    localparam int c_bank_bits = calc_bank_bits(NUM_BANKS);
    localparam int c_rows      = calc_rows(RAM_SIZE, NUM_BANKS);
    localparam int c_row_bits  = calc_row_bits(c_rows);
    localparam int c_addr_bits = $clog2(RAM_SIZE);
    localparam logic [c_row_bits-1:0] c_last_row = c_row_bits'(c_rows - 1);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("sp_ram_banked_wrap: only DATA_WIDTH=32 is supported");
    end
    if (NUM_BANKS < 1 || NUM_BANKS > 16 || (1 << c_bank_bits) != NUM_BANKS) begin : g_bad_num_banks
        $error("sp_ram_banked_wrap: NUM_BANKS must be a power of 2 in 1..16");
    end

    state_e                r_state;
    logic [c_row_bits-1:0] r_init_row;
    logic                  r_init_done;

    bank_row_t             w_map;
    logic [c_row_bits-1:0] w_row;
    logic                  w_in_range;
    logic                  w_gnt;
    logic                  w_access;
    logic                  w_init_wr;
    logic                  w_unused;
    logic [31:0]           w_bank_rdata [NUM_BANKS];

    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_rsp_rd;
    logic [3:0]            r_rsp_bank;
    logic [31:0]           w_rsp_rdata;

    assign w_map      = addr_to_bank_row(addr_i, c_bank_bits);
    assign w_row      = w_map.row[c_row_bits-1:0];
    assign w_in_range = ((addr_i >> c_addr_bits) == 32'd0);
    assign w_gnt      = req_i && rstn_i && (r_state == RUN);
    assign w_access   = w_gnt && w_in_range;
    assign w_init_wr  = rstn_i && (r_state == INIT);
    assign w_unused   = ^{addr_i[1:0], w_map};

    assign gnt_o       = w_gnt;
    assign init_done_o = r_init_done;

    // Sequencer: zero-fill one row of every bank per cycle, then serve requests
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            if (INIT_ZERO != 0) begin
                r_state <= INIT;
            end else begin
                r_state <= RUN;
            end
            r_init_row  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_init_row == c_last_row) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_init_row <= r_init_row + c_row_bits'(1);
                    end
                end
                default: r_init_done <= 1'b1;
            endcase
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_sel;
        assign w_sel = (w_map.bank == 4'(b));

        sp_ram_bank #(
            .ROWS     (c_rows),
            .ROW_BITS (c_row_bits)
        ) u_bank (
            .clk   (clk),
            .en    (w_init_wr || (w_access && w_sel)),
            .we    (w_init_wr || we_i),
            .be    (w_init_wr ? 4'hF : be_i),
            .addr  (w_init_wr ? r_init_row : w_row),
            .wdata (w_init_wr ? 32'd0 : wdata_i),
            .rdata (w_bank_rdata[b])
        );
    end

    // Remember what was granted so the bank outputs can be steered next cycle
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rd    <= 1'b0;
            r_rsp_bank  <= '0;
        end else begin
            r_rsp_valid <= w_gnt;
            r_rsp_err   <= w_gnt && !w_in_range;
            r_rsp_rd    <= w_access && !we_i;
            r_rsp_bank  <= w_map.bank;
        end
    end

    // Bank read mux; zero unless the response is an in-range read
    always_comb begin
        w_rsp_rdata = '0;
        if (r_rsp_rd) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (r_rsp_bank == 4'(b)) begin
                    w_rsp_rdata = w_bank_rdata[b];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic        r_out_valid;
        logic        r_out_err;
        logic [31:0] r_out_rdata;

        // Extra response stage for timing; cleared by reset like the first
        always_ff @(posedge clk) begin
            if (!rstn_i) begin
                r_out_valid <= 1'b0;
                r_out_err   <= 1'b0;
                r_out_rdata <= '0;
            end else begin
                r_out_valid <= r_rsp_valid;
                r_out_err   <= r_rsp_err;
                r_out_rdata <= w_rsp_rdata;
            end
        end

        assign rvalid_o = r_out_valid;
        assign err_o    = r_out_err;
        assign rdata_o  = r_out_rdata;
    end else begin : g_out_comb
        assign rvalid_o = r_rsp_valid;
        assign err_o    = r_rsp_err;
        assign rdata_o  = w_rsp_rdata;
    end

endmodule
`default_nettype wire
